// File: rtl/shared_mem_responder_if.sv
// Request/response bundle between the MEM-stage LSU (master) and the shared
// memory responder (slave).
interface shared_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [3:0]  req_mask;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_we, req_mask, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_mask, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/shared_mem_responder.sv
// Word-addressed shared data memory with programmable wait states, answering
// one load/store per handshake with a single-cycle response.
module shared_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input logic                   clk,
  input logic                   rst,
  shared_mem_responder_if.slave bus
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [3:0]  mask_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic             ready, hs, do_access, acc_err;
  logic [31:0]      offset;
  logic [IDX_W-1:0] idx;

  // Addresses below the base wrap to huge offsets, so one compare covers both bounds.
  assign offset    = addr_q - ADDR_BASE;
  assign acc_err   = (addr_q[1:0] != 2'b00) || ({1'b0, offset} >= SPAN);
  assign idx       = offset[IDX_W+1:2];
  assign ready     = (state_q != ACCESS) && !rst;
  assign hs        = bus.req_valid && ready;
  assign do_access = (state_q == ACCESS) && (cnt_q == 4'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          state_d = ACCESS;
          cnt_d   = 4'(WAIT_STATES);
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RESP;
          err_d   = acc_err;
          rdata_d = (acc_err || we_q) ? '0 : mem_q[idx];
        end
      end
      RESP: begin
        if (hs) begin
          state_d = ACCESS;
          cnt_d   = 4'(WAIT_STATES);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (hs) begin
      we_q    <= bus.req_we;
      mask_q  <= bus.req_mask;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end
  end

  // Reset forces IDLE, so a store whose access edge has not yet come is dropped.
  always_ff @(posedge clk) begin
    if (do_access && we_q && !acc_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (mask_q[i]) mem_q[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.busy      = (state_q == ACCESS);

endmodule

// File: tb/tb_shared_mem_responder.sv
// Scoreboard bench for shared_mem_responder across four parameter sets
// (wait states 0/1/3/15, one with a non-zero base and smaller depth).
module tb_shared_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int sel      = 1;

  logic        d_valid = 1'b0, d_we = 1'b0;
  logic [3:0]  d_mask  = '0;
  logic [31:0] d_addr  = '0, d_wdata = '0;
  logic        s_ready, s_rvalid, s_err, s_busy;
  logic [31:0] s_rdata;

  int unsigned ws_of    [4] = '{0, 1, 3, 15};
  int unsigned depth_of [4] = '{1024, 1024, 256, 1024};
  logic [31:0] base_of  [4] = '{32'h0, 32'h0, 32'h0001_0000, 32'h0};

  shared_mem_responder_if if_ws0();
  shared_mem_responder_if if_ws1();
  shared_mem_responder_if if_ws3();
  shared_mem_responder_if if_ws15();

  shared_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0))
    u_ws0 (.clk(clk), .rst(rst), .bus(if_ws0));
  shared_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1))
    u_ws1 (.clk(clk), .rst(rst), .bus(if_ws1));
  shared_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(3), .ADDR_BASE(32'h0001_0000))
    u_ws3 (.clk(clk), .rst(rst), .bus(if_ws3));
  shared_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(15))
    u_ws15 (.clk(clk), .rst(rst), .bus(if_ws15));

  assign if_ws0.req_valid  = d_valid && (sel == 0);
  assign if_ws1.req_valid  = d_valid && (sel == 1);
  assign if_ws3.req_valid  = d_valid && (sel == 2);
  assign if_ws15.req_valid = d_valid && (sel == 3);
  assign if_ws0.req_we  = d_we;   assign if_ws1.req_we  = d_we;
  assign if_ws3.req_we  = d_we;   assign if_ws15.req_we = d_we;
  assign if_ws0.req_mask  = d_mask;  assign if_ws1.req_mask  = d_mask;
  assign if_ws3.req_mask  = d_mask;  assign if_ws15.req_mask = d_mask;
  assign if_ws0.req_addr  = d_addr;  assign if_ws1.req_addr  = d_addr;
  assign if_ws3.req_addr  = d_addr;  assign if_ws15.req_addr = d_addr;
  assign if_ws0.req_wdata = d_wdata; assign if_ws1.req_wdata = d_wdata;
  assign if_ws3.req_wdata = d_wdata; assign if_ws15.req_wdata = d_wdata;

  always_comb begin
    s_ready = if_ws1.req_ready; s_rvalid = if_ws1.rsp_valid;
    s_rdata = if_ws1.rsp_rdata; s_err = if_ws1.rsp_err; s_busy = if_ws1.busy;
    case (sel)
      0: begin
        s_ready = if_ws0.req_ready; s_rvalid = if_ws0.rsp_valid;
        s_rdata = if_ws0.rsp_rdata; s_err = if_ws0.rsp_err; s_busy = if_ws0.busy;
      end
      2: begin
        s_ready = if_ws3.req_ready; s_rvalid = if_ws3.rsp_valid;
        s_rdata = if_ws3.rsp_rdata; s_err = if_ws3.rsp_err; s_busy = if_ws3.busy;
      end
      3: begin
        s_ready = if_ws15.req_ready; s_rvalid = if_ws15.rsp_valid;
        s_rdata = if_ws15.rsp_rdata; s_err = if_ws15.rsp_err; s_busy = if_ws15.busy;
      end
      default: ;
    endcase
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          hs_cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl [4][1024];

  // Reference memory: result and side effect of one request on instance s.
  function automatic exp_t model_access(int s, logic we, logic [3:0] m,
                                        logic [31:0] a, logic [31:0] w);
    exp_t        e;
    logic [31:0] off;
    int unsigned idx;
    off     = a - base_of[s];
    e.rdata = '0;
    e.err   = (a[1:0] != 2'b00) || (off >= 32'(4 * depth_of[s]));
    e.hs_cyc = 0;
    if (!e.err) begin
      idx = int'(off >> 2);
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (m[i]) mdl[s][idx][8*i +: 8] = w[8*i +: 8];
      end else begin
        e.rdata = mdl[s][idx];
      end
    end
    return e;
  endfunction

  task automatic tick(output logic hs);
    exp_t e;
    hs = d_valid && s_ready;
    @(posedge clk);
    cyc++;
    if (hs) begin
      e = model_access(sel, d_we, d_mask, d_addr, d_wdata);
      e.hs_cyc = cyc;
      sb.push_back(e);
    end
    #1;
  endtask

  // Issue one request and wait (bounded) for its response; no checking here.
  task automatic req(input logic we, input logic [3:0] m, input logic [31:0] a,
                     input logic [31:0] w, output bit got, output exp_t e,
                     output int lat, output logic [31:0] rd, output logic er,
                     output int bad_rdy);
    logic hs;
    bit   ok;
    got = 0; lat = -1; rd = 'x; er = 1'bx; bad_rdy = 0;
    e.rdata = '0; e.err = 1'b0; e.hs_cyc = 0;
    d_we = we; d_mask = m; d_addr = a; d_wdata = w; d_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick(hs);
      ok = hs;
    end
    d_valid = 1'b0;
    if (!ok) return;
    for (int i = 0; i < 40; i++) begin
      if (s_rvalid) begin got = 1; break; end
      if (s_ready) bad_rdy++;
      tick(hs);
    end
    if (got && sb.size() > 0) begin
      e  = sb.pop_front();
      lat = cyc - e.hs_cyc;
      rd = s_rdata;
      er = s_err;
    end else begin
      got = 0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b want=0", s_ready); end
    checks++; if (if_ws0.req_ready !== 1'b0 || if_ws15.req_ready !== 1'b0) begin
      failures++; $display("FAIL rst_ready_all got=%b%b want=00", if_ws0.req_ready, if_ws15.req_ready); end
    checks++; if (s_rvalid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%b want=0", s_rvalid); end
    checks++; if (s_rdata !== 32'h0 || s_err !== 1'b0) begin
      failures++; $display("FAIL rst_rsp got=%h/%b want=00000000/0", s_rdata, s_err); end
    checks++; if (s_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b want=0", s_busy); end
    rst = 1'b0;
    #1;
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%b want=1", s_ready); end
  endtask

  task automatic test_store_load();
    bit got; exp_t e; int lat, br; logic [31:0] rd; logic er;
    sel = 1;
    req(1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, got, e, lat, rd, er, br);
    checks++; if (!got) begin failures++; $display("FAIL st_rsp got=none want=rsp_valid"); end
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin failures++; $display("FAIL st_rdata got=%h/%b want=00000000/0", rd, er); end
    checks++; if (lat != 2) begin failures++; $display("FAIL st_latency got=%0d want=2", lat); end
    req(1'b0, 4'h0, 32'h10, 32'h0, got, e, lat, rd, er, br);
    checks++; if (!got) begin failures++; $display("FAIL ld_rsp got=none want=rsp_valid"); end
    checks++; if (rd !== 32'hDEAD_BEEF || rd !== e.rdata) begin
      failures++; $display("FAIL ld_rdata got=%h want=%h", rd, e.rdata); end
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL ld_err got=%b want=0", er); end
    checks++; if (lat != 2 || br != 0) begin failures++; $display("FAIL ld_latency got=%0d/%0d want=2/0", lat, br); end
  endtask

  task automatic test_byte_merge();
    bit got; exp_t e; int lat, br; logic [31:0] rd; logic er;
    sel = 1;
    req(1'b1, 4'hF, 32'h20, 32'h1122_3344, got, e, lat, rd, er, br);
    req(1'b1, 4'b0101, 32'h20, 32'hAABB_CCDD, got, e, lat, rd, er, br);
    checks++; if (!got || rd !== 32'h0) begin failures++; $display("FAIL merge_st got=%0d/%h want=1/00000000", got, rd); end
    req(1'b0, 4'h0, 32'h20, 32'h0, got, e, lat, rd, er, br);
    checks++; if (!got || rd !== 32'h11BB_33DD || rd !== e.rdata) begin
      failures++; $display("FAIL merge_ld got=%h want=%h", rd, e.rdata); end
    req(1'b1, 4'b0000, 32'h20, 32'hFFFF_FFFF, got, e, lat, rd, er, br);
    checks++; if (!got || er !== 1'b0) begin failures++; $display("FAIL mask0_rsp got=%0d/%b want=1/0", got, er); end
    req(1'b0, 4'h0, 32'h20, 32'h0, got, e, lat, rd, er, br);
    checks++; if (!got || rd !== e.rdata) begin failures++; $display("FAIL mask0_ld got=%h want=%h", rd, e.rdata); end
  endtask

  task automatic test_errors();
    bit got; exp_t e; int lat, br; logic [31:0] rd; logic er;
    logic [31:0] bad [3];
    sel = 1;
    req(1'b0, 4'h0, 32'h13, 32'h0, got, e, lat, rd, er, br);
    checks++; if (!got || er !== 1'b1 || rd !== 32'h0) begin
      failures++; $display("FAIL err_misalign got=%b/%h want=1/00000000", er, rd); end
    req(1'b0, 4'h0, 32'h0000_1000, 32'h0, got, e, lat, rd, er, br);
    checks++; if (!got || er !== 1'b1 || rd !== 32'h0) begin
      failures++; $display("FAIL err_range got=%b/%h want=1/00000000", er, rd); end
    req(1'b1, 4'hF, 32'h0000_1010, 32'h5555_AAAA, got, e, lat, rd, er, br);
    checks++; if (!got || er !== e.err || er !== 1'b1) begin failures++; $display("FAIL err_store got=%b want=1", er); end
    req(1'b0, 4'h0, 32'h10, 32'h0, got, e, lat, rd, er, br);
    checks++; if (!got || rd !== e.rdata) begin failures++; $display("FAIL err_nowrite10 got=%h want=%h", rd, e.rdata); end
    req(1'b0, 4'h0, 32'h20, 32'h0, got, e, lat, rd, er, br);
    checks++; if (!got || rd !== e.rdata) begin failures++; $display("FAIL err_nowrite20 got=%h want=%h", rd, e.rdata); end
    // Non-zero base instance: top word is legal, neighbours on both sides are not.
    sel = 2;
    req(1'b1, 4'hF, 32'h0001_03FC, 32'hCAFE_0123, got, e, lat, rd, er, br);
    req(1'b0, 4'h0, 32'h0001_03FC, 32'h0, got, e, lat, rd, er, br);
    checks++; if (!got || er !== 1'b0 || rd !== e.rdata) begin
      failures++; $display("FAIL base_top got=%b/%h want=0/%h", er, rd, e.rdata); end
    bad[0] = 32'h0000_FFFC; bad[1] = 32'h0001_0400; bad[2] = 32'h0001_0002;
    for (int i = 0; i < 3; i++) begin
      req(1'b0, 4'h0, bad[i], 32'h0, got, e, lat, rd, er, br);
      checks++; if (!got || er !== e.err || er !== 1'b1 || rd !== 32'h0) begin
        failures++; $display("FAIL base_err%0d got=%b/%h want=1/00000000", i, er, rd); end
    end
  endtask

  task automatic test_back_to_back();
    bit got; exp_t e; int lat, br; logic [31:0] rd; logic er;
    logic [31:0] a [4];
    logic [31:0] v [4];
    logic [7:0]  rpat;
    logic        hs;
    int          nrsp, k;
    sel = 0;
    for (int i = 0; i < 4; i++) begin
      a[i] = 32'h40 + 32'(4 * i);
      v[i] = $urandom;
      req(1'b1, 4'hF, a[i], v[i], got, e, lat, rd, er, br);
    end
    checks++; if (!got) begin failures++; $display("FAIL b2b_preload got=none want=rsp_valid"); end
    k = 0; nrsp = 0; rpat = '0;
    d_we = 1'b0; d_mask = 4'h0; d_addr = a[0]; d_valid = 1'b1;
    for (int t = 0; t < 8; t++) begin
      rpat[7-t] = s_ready;
      tick(hs);
      if (hs) begin
        k++;
        if (k < 4) d_addr = a[k]; else d_valid = 1'b0;
      end
      if (s_rvalid) begin
        checks++;
        if (sb.size() == 0 || nrsp >= 4) begin
          failures++; $display("FAIL b2b_extra got=rsp%0d want=none", nrsp);
        end else begin
          e = sb.pop_front();
          if (s_rdata !== e.rdata || s_rdata !== v[nrsp]) begin
            failures++; $display("FAIL b2b_data%0d got=%h want=%h", nrsp, s_rdata, v[nrsp]);
          end
        end
        nrsp++;
      end
    end
    d_valid = 1'b0;
    checks++; if (rpat !== 8'b1010_1010) begin failures++; $display("FAIL b2b_ready got=%b want=10101010", rpat); end
    checks++; if (nrsp != 4) begin failures++; $display("FAIL b2b_count got=%0d want=4", nrsp); end
  endtask

  task automatic test_wait_sweep();
    bit got; exp_t e; int lat, br; logic [31:0] rd; logic er;
    int s_list [3] = '{0, 2, 3};
    for (int j = 0; j < 3; j++) begin
      sel = s_list[j];
      req(1'b1, 4'hF, base_of[sel] + 32'h8, 32'h1234_0000 + 32'(j), got, e, lat, rd, er, br);
      req(1'b0, 4'h0, base_of[sel] + 32'h8, 32'h0, got, e, lat, rd, er, br);
      checks++; if (!got || lat != int'(ws_of[sel]) + 1) begin
        failures++; $display("FAIL sweep_lat_ws%0d got=%0d want=%0d", ws_of[sel], lat, ws_of[sel] + 1); end
      checks++; if (br != 0) begin failures++; $display("FAIL sweep_ready_ws%0d got=%0d want=0", ws_of[sel], br); end
      checks++; if (rd !== e.rdata) begin failures++; $display("FAIL sweep_data_ws%0d got=%h want=%h", ws_of[sel], rd, e.rdata); end
    end
  endtask

  task automatic test_reset_mid_access();
    bit got; exp_t e; int lat, br; logic [31:0] rd; logic er;
    logic [31:0] addr, saved;
    logic        hs, sawv;
    sel  = 2;
    addr = 32'h0001_0030;
    req(1'b1, 4'hF, addr, 32'h0BAD_F00D, got, e, lat, rd, er, br);
    saved = mdl[2][12];
    d_we = 1'b1; d_mask = 4'hF; d_addr = addr; d_wdata = 32'hFFFF_FFFF; d_valid = 1'b1;
    tick(hs);
    d_valid = 1'b0;
    checks++; if (hs !== 1'b1) begin failures++; $display("FAIL rma_hs got=%b want=1", hs); end
    tick(hs);
    checks++; if (s_busy !== 1'b1) begin failures++; $display("FAIL rma_busy got=%b want=1", s_busy); end
    rst = 1'b1;
    #1;
    checks++; if (s_ready !== 1'b0 || s_busy !== 1'b0) begin
      failures++; $display("FAIL rma_in_rst got=%b/%b want=0/0", s_ready, s_busy); end
    sawv = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(hs); if (s_rvalid) sawv = 1'b1; end
    rst = 1'b0;
    #1;
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL rma_release got=%b want=1", s_ready); end
    mdl[2][12] = saved;
    sb.delete();
    for (int i = 0; i < 6; i++) begin tick(hs); if (s_rvalid) sawv = 1'b1; end
    checks++; if (sawv !== 1'b0) begin failures++; $display("FAIL rma_no_rsp got=%b want=0", sawv); end
    req(1'b0, 4'h0, addr, 32'h0, got, e, lat, rd, er, br);
    checks++; if (!got || rd !== 32'h0BAD_F00D || rd !== e.rdata) begin
      failures++; $display("FAIL rma_word got=%h want=%h", rd, e.rdata); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_merge();
    test_errors();
    test_back_to_back();
    test_wait_sweep();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
